// File: rtl/wb_ram_responder.sv
// Wishbone classic slave over a line-wide RAM; every request ends in exactly one of ack/err/rty.
// err/rty one cycle after the request, ack WAIT_STATES cycles later; busy_i turns new requests into rty.
module wb_ram_responder #(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    GRANULARITY = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wb_cyc_i,
    input  logic                              wb_stb_i,
    input  logic                              wb_we_i,
    input  logic [ADDR_WIDTH-1:0]             wb_adr_i,
    input  logic [DATA_WIDTH/GRANULARITY-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]             wb_dat_i,
    output logic [DATA_WIDTH-1:0]             wb_dat_o,
    output logic                              wb_ack_o,
    output logic                              wb_err_o,
    output logic                              wb_rty_o,
    input  logic                              busy_i
);

    localparam int                    LANES     = DATA_WIDTH / GRANULARITY;
    localparam int                    LANE_LOG2 = $clog2(LANES);
    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [3:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_RTY
    } state_t;

    state_t state;
    state_t next_state;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       latch;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] line_q;
    logic                  we_q;
    logic [LANES-1:0]      sel_q;
    logic [DATA_WIDTH-1:0] dat_q;

    // Address decode; the extra top bit of diff is the borrow, i.e. adr below BASE_ADDR.
    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] off;
    logic                  under;
    logic                  misaligned;
    logic                  out_range;
    logic                  bad;
    logic                  request;
    logic [DEPTH_LOG2-1:0] line_in;

    assign diff       = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
    assign off        = diff[ADDR_WIDTH-1:0];
    assign under      = diff[ADDR_WIDTH];
    assign misaligned = (off & LANE_MASK) != '0;
    assign out_range  = (off >> (LANE_LOG2 + DEPTH_LOG2)) != '0;
    assign bad        = under | misaligned | out_range;
    assign line_in    = DEPTH_LOG2'(off >> LANE_LOG2);
    assign request    = wb_cyc_i & wb_stb_i;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (request) begin
                    latch = 1'b1;
                    if (bad) begin
                        next_state = S_ERR;
                    end else if (busy_i) begin
                        next_state = S_RTY;
                    end else if (WAIT_STATES == 0) begin
                        next_state = S_ACK;
                    end else begin
                        cnt_next   = WAIT_LOAD;
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    next_state = S_IDLE;
                end else if (cnt == 4'd0) begin
                    next_state = S_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // With no wait states the commit happens on the same edge that latches, so take the bus directly.
    logic                  commit;
    logic                  from_bus;
    logic [DEPTH_LOG2-1:0] line_c;
    logic                  we_c;
    logic [LANES-1:0]      sel_c;
    logic [DATA_WIDTH-1:0] dat_c;

    assign commit   = (next_state == S_ACK);
    assign from_bus = (state == S_IDLE);
    assign line_c   = from_bus ? line_in  : line_q;
    assign we_c     = from_bus ? wb_we_i  : we_q;
    assign sel_c    = from_bus ? wb_sel_i : sel_q;
    assign dat_c    = from_bus ? wb_dat_i : dat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            wb_dat_o <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (commit) begin
                wb_dat_o <= mem[line_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            line_q <= line_in;
            we_q   <= wb_we_i;
            sel_q  <= wb_sel_i;
            dat_q  <= wb_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && commit && we_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel_c[i]) begin
                    mem[line_c][i*GRANULARITY +: GRANULARITY] <= dat_c[i*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    assign wb_ack_o = (state == S_ACK);
    assign wb_err_o = (state == S_ERR);
    assign wb_rty_o = (state == S_RTY);

endmodule

// File: tb/tb_wb_ram_responder.sv
// Three responders (0, 1 and 3 wait states) on a shared bus; cyc is steered to one at a time.
// A transaction-level model predicts response kind, response cycle and read data per instance.
module tb_wb_ram_responder;

    localparam int NI     = 3;
    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_RTY  = 3;
    localparam logic [127:0] PAT  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] PART = 128'h44444444_33333333_DEADBEEF_11111111;
    localparam logic [127:0] A5   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we, busy;
    logic [31:0]  adr;
    logic [3:0]   sel;
    logic [127:0] dat;
    int           act;

    logic [127:0] dat_o [NI];
    logic         ack_o [NI];
    logic         err_o [NI];
    logic         rty_o [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wb_ram_responder #(
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wb_cyc_i (cyc && (act == g)),
            .wb_stb_i (stb),
            .wb_we_i  (we),
            .wb_adr_i (adr),
            .wb_sel_i (sel),
            .wb_dat_i (dat),
            .wb_dat_o (dat_o[g]),
            .wb_ack_o (ack_o[g]),
            .wb_err_o (err_o[g]),
            .wb_rty_o (rty_o[g]),
            .busy_i   (busy)
        );
    end

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    logic rst_q = 1'b0;
    bit chk_en = 1'b0;

    // Model state: per-instance RAM image with known-lane mask, and the one outstanding expectation.
    logic [127:0] mm [NI][1024];
    logic [3:0]   kn [NI][1024];
    int           exp_cyc  [NI];
    int           exp_kind [NI];
    logic [127:0] exp_dat  [NI];
    logic [3:0]   exp_mask [NI];
    int           last_resp[NI];
    logic [127:0] hold     [NI];
    logic [3:0]   hmask    [NI];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        rst_q <= rst;
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [127:0] ex(input logic [3:0] m);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = {32{m[i]}};
        return r;
    endfunction

    task automatic chk_bit(input string nm, input int k, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s[%0d] cycle %0d got=%0b want=%0b", nm, k, cyc_n, got, want);
        end
    endtask

    task automatic lit(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                logic ea, ee, er;
                logic [127:0] m;
                if (!rst_q) begin
                    hold[k]  = '0;
                    hmask[k] = 4'hF;
                end
                ea = rst_q && (exp_cyc[k] == cyc_n) && (exp_kind[k] == K_ACK);
                ee = rst_q && (exp_cyc[k] == cyc_n) && (exp_kind[k] == K_ERR);
                er = rst_q && (exp_cyc[k] == cyc_n) && (exp_kind[k] == K_RTY);
                if (ea) begin
                    hold[k]  = exp_dat[k];
                    hmask[k] = exp_mask[k];
                end
                chk_bit("ack", k, ack_o[k], ea);
                chk_bit("err", k, err_o[k], ee);
                chk_bit("rty", k, rty_o[k], er);
                chk_bit("onehot", k, (32'(ack_o[k]) + 32'(err_o[k]) + 32'(rty_o[k])) <= 1, 1'b1);
                m = ex(hmask[k]);
                checks++;
                if ((dat_o[k] & m) !== (hold[k] & m)) begin
                    failures++;
                    $display("FAIL dat_o[%0d] cycle %0d got=%h want=%h mask=%h",
                             k, cyc_n, dat_o[k], hold[k], m);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0;
        stb = 1'b0;
        repeat (n) step();
    endtask

    // Present a request and return in its response cycle, leaving it asserted for a back-to-back follow-up.
    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d, input logic b, input bit rb);
        int smp, tgt, ln;
        act = k; cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; busy = b;
        smp = (cyc_n > last_resp[k]) ? cyc_n : last_resp[k] + 1;
        if (a[1:0] != 2'b00 || (a >> 2) >= 32'd1024) begin
            exp_kind[k] = K_ERR;
            tgt = smp + 1;
        end else if (b) begin
            exp_kind[k] = K_RTY;
            tgt = smp + 1;
        end else begin
            ln = int'(a >> 2);
            exp_kind[k] = K_ACK;
            exp_dat[k]  = mm[k][ln];
            exp_mask[k] = kn[k][ln];
            tgt = smp + 1 + ws_of(k);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) begin
                        mm[k][ln][i*32 +: 32] = d[i*32 +: 32];
                        kn[k][ln][i] = 1'b1;
                    end
                end
            end
        end
        exp_cyc[k]   = tgt;
        last_resp[k] = tgt;
        while (cyc_n < tgt) begin
            step();
            if (rb && cyc_n > smp) busy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic abort_wr(input int k, input logic [31:0] a, input logic [127:0] d);
        int smp;
        act = k; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat = d; busy = 1'b0;
        smp = (cyc_n > last_resp[k]) ? cyc_n : last_resp[k] + 1;
        exp_kind[k] = K_NONE;
        exp_cyc[k]  = -1;
        while (cyc_n < smp + 2) step();
        cyc = 1'b0;
        stb = 1'b0;
        last_resp[k] = smp + 2;
    endtask

    initial begin
        int k, r;
        logic [31:0] a;
        for (int i = 0; i < NI; i++) begin
            exp_cyc[i]   = -1;
            exp_kind[i]  = K_NONE;
            last_resp[i] = -100;
            hold[i]      = '0;
            hmask[i]     = 4'hF;
            for (int j = 0; j < 1024; j++) kn[i][j] = 4'h0;
        end
        rst = 1'b0; act = 1; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = 32'h10; sel = 4'hF; dat = '0; busy = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b1;
        issue(1, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < NI; i++) begin
            issue(i, 1'b1, 32'h10, 4'hF, PAT, 1'b0, 1'b0);
            idle(1);
            issue(i, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0);
            lit($sformatf("rd_full_k%0d", i), dat_o[i], PAT);
            idle(1);
        end

        issue(1, 1'b1, 32'h10, 4'b0010, 128'h00000000_00000000_DEADBEEF_00000000, 1'b0, 1'b0);
        idle(1);
        issue(1, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0);
        lit("rd_partial", dat_o[1], PART);
        idle(1);

        issue(1, 1'b0, 32'h11, 4'hF, '0, 1'b0, 1'b0);
        idle(1);
        issue(1, 1'b1, 32'h1000, 4'hF, ~PAT, 1'b0, 1'b0);
        idle(1);
        issue(1, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0);
        lit("rd_after_err", dat_o[1], PART);
        idle(1);

        issue(1, 1'b1, 32'h10, 4'hF, '0, 1'b1, 1'b0);
        idle(1);
        issue(1, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0);
        lit("rd_after_rty", dat_o[1], PART);
        idle(1);

        issue(2, 1'b1, 32'h20, 4'hF, A5, 1'b0, 1'b0);
        idle(1);
        abort_wr(2, 32'h20, '0);
        idle(5);
        issue(2, 1'b0, 32'h20, 4'hF, '0, 1'b0, 1'b0);
        lit("rd_after_abort", dat_o[2], A5);
        idle(1);

        for (int i = 0; i < 4; i++)
            issue(1, 1'b1, 32'(i * 4), 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(1, 1'b0, 32'(i * 4), 4'hF, '0, 1'b0, 1'b0);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, NI - 1);
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) a = 32'd4092;
            else if (r == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom()),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  ($urandom_range(0, 4) == 0), 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ram_responder.md
# wb_ram_responder

Wishbone classic-cycle responder backing a line-wide on-chip RAM. It is the slave end of the CPU's external bus: it accepts the 128-bit, 32-bit-granular requests the memory controller issues on `wb_*`, and answers each one with exactly one of ack, err or rty. The block serves as system RAM on the FPGA build and as the bus model in CPU-level simulation.

## Interface
- `DATA_WIDTH`, 128, bus and line width in bits.
- `GRANULARITY`, 32, bits per address unit and per select lane.
- `ADDR_WIDTH`, 32, bus address width.
- `DEPTH_LOG2`, 10, log2 of the number of RAM lines.
- `BASE_ADDR`, 0, first address unit decoded. Must be line-aligned.
- `WAIT_STATES`, 1, extra cycles before ack. Range 0..15.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-low.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  ADDR_WIDTH  address, in GRANULARITY units.
- `wb_sel_i`  in  DATA_WIDTH/GRANULARITY  lane enables. Bit i covers `[GRANULARITY*i +: GRANULARITY]`.
- `wb_dat_i`  in  DATA_WIDTH  write data.
- `wb_dat_o`  out  DATA_WIDTH  read data.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `wb_rty_o`  out  1  retry termination.
- `busy_i`  in  1  while high, new requests are refused with rty.

## Operation
- Definitions: L = DATA_WIDTH/GRANULARITY (4 by default). off = wb_adr_i − BASE_ADDR. line = off >> log2(L).
- A request is cyc_i & stb_i sampled high while the FSM is in IDLE.
- States:
  - **IDLE**. On a request, adr/we/sel/dat are latched, then:
    - If off[log2(L)-1:0] ≠ 0, or wb_adr_i < BASE_ADDR, or line ≥ 2^DEPTH_LOG2, go to ERR.
    - Else if busy_i is high, go to RTY.
    - Else if WAIT_STATES = 0, go to ACK.
    - Else load the counter with WAIT_STATES−1 and go to WAIT.
    - Decode has priority over busy.
  - **WAIT**. Decrement the counter; at 0 go to ACK. If cyc_i drops, return to IDLE: no write, no response.
  - **ACK**, **ERR**, **RTY**. Each lasts one cycle with its output high, then returns to IDLE.
- Write commit: on the edge entering ACK, each RAM lane with its latched sel bit set is written from the latched dat. Other lanes keep their value. ERR, RTY and aborted requests never modify the RAM.
- Read: on the edge entering ACK, wb_dat_o loads the RAM line. This happens on reads and on writes; on a write, wb_dat_o shows the pre-write contents. wb_dat_o holds its value until the next ACK.
- Responses are one-hot: at most one of ack/err/rty is high in any cycle.
- A request still present in the cycle after a response cycle is sampled as a new request.
- RAM contents are not reset and start undefined.

## Timing
- Reset (rst = 0 at an edge): FSM goes to IDLE, counter = 0, wb_ack_o = wb_err_o = wb_rty_o = 0, wb_dat_o = 0. Any in-flight request is dropped without a RAM write.
- For a request sampled at the end of cycle c:
  - err or rty is high in cycle c+1.
  - ack is high in cycle c+1+WAIT_STATES.
- Throughput: one transfer per 2+WAIT_STATES cycles for back-to-back requests.
- A write acked in cycle n is visible to a read request sampled in cycle n+1 or later.
- busy_i is sampled only in IDLE. Changes during WAIT have no effect.

## Test plan
- **Reset.** Hold rst = 0 for 3 cycles with cyc = stb = 1, then release. Required: all responses 0 while in reset, wb_dat_o = 0, and the first ack arrives exactly 2 cycles after release (WAIT_STATES = 1).
- **Full write, then read.**
  - Write adr 0x10, sel 4'hF, data 0x44444444_33333333_22222222_11111111. Ack must arrive in cycle c+2.
  - Read adr 0x10. Ack in c+2 with wb_dat_o equal to the written value.
  - Repeat with WAIT_STATES = 0 (ack in c+1) and WAIT_STATES = 3 (ack in c+4).
- **Partial lanes.** After the full write, write adr 0x10 with sel 4'b0010 and data 0xDEADBEEF in lane 1. Read-back must return 0x44444444_33333333_DEADBEEF_11111111.
- **Decode errors.**
  - Read adr 0x11 (misaligned): err in c+1.
  - Write adr 0x1000 with DEPTH_LOG2 = 10 (out of range): err in c+1.
  - In both cases no ack; a later read of 0x10 is unchanged.
- **Retry and abort.**
  - busy_i = 1 at request: rty in c+1, RAM unchanged.
  - With WAIT_STATES = 3, drop cyc in cycle c+2 of a write to 0x20: no response is ever issued, and a later read of 0x20 returns the old data.
- **Back-to-back.** Hold stb for 4 consecutive writes to 0x0, 0x4, 0x8, 0xC, then 4 reads. Required: acks spaced exactly 3 cycles apart (WAIT_STATES = 1), all data correct, never two responses in the same cycle.
